// File: rtl/instr_encoder.sv
// instr_encoder: packs field bundles into 16-bit instruction words and writes
// them to consecutive instruction-memory addresses. A load starts at
// base_addr. It stops at the top of the address space without wrapping.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [2:0]        opcode,
  input  logic [1:0]        alu_op,
  input  logic [1:0]        shift_op,
  input  logic [2:0]        rn,
  input  logic [2:0]        rd,
  input  logic [2:0]        rm,
  input  logic [15:0]       imm,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_write,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic              full
);

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    WRITE,
    FULL
  } state_t;

  state_t      state;
  logic [15:0] word;
  logic        legal;

  // start overrides everything in its cycle. Gating the handshake and the
  // write strobe with it means a bundle offered alongside start is not taken.
  // It also means a write that is pending when start arrives never reaches
  // memory.
  assign in_ready  = (state == ACCEPT) && !start;
  assign mem_write = (state == WRITE) && !start;

  // Pack the word for the current bundle, and decide whether the immediate fits its field.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    word  = {opcode, alu_op, rn, 8'h00};
    legal = 1'b0;
    case (fmt)
      2'b00: begin
        word[7:0] = {rd, shift_op, rm};
        legal     = 1'b1;
      end
      2'b01: begin
        word[7:0] = imm[7:0];
        // imm fits in 8 signed bits only when bits 15..7 are all copies of the sign.
        legal     = (&imm[15:7]) || !(|imm[15:7]);
      end
      2'b10: begin
        word[7:0] = {rd, imm[4:0]};
        legal     = (&imm[15:4]) || !(|imm[15:4]);
      end
      default: legal = 1'b0;
    endcase
  end

  // Load FSM. It also holds the registered address, data, count and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (!rst_n) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      err       <= 1'b0;
      full      <= 1'b0;
    end else if (start) begin
      state    <= ACCEPT;
      mem_addr <= base_addr;
      count    <= '0;
      err      <= 1'b0;
      full     <= 1'b0;
    end else begin
      case (state)
        ACCEPT: begin
          if (in_valid) begin
            if (legal) begin
              mem_wdata <= word;
              // count advances at capture. It then already includes the
              // word in the cycle that word is written. If the write is
              // cancelled by start or reset, count is cleared as well.
              count     <= count + (ADDR_W+1)'(1);
              state     <= WRITE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (&mem_addr) begin
            state <= FULL;
            full  <= 1'b1;
          end else begin
            mem_addr <= mem_addr + ADDR_W'(1);
            state    <= ACCEPT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder. Each expected memory write is queued when
// its bundle is driven. A monitor pops the entry and compares it when
// mem_write fires.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fmt;
  logic [2:0]  opcode;
  logic [1:0]  alu_op;
  logic [1:0]  shift_op;
  logic [2:0]  rn;
  logic [2:0]  rd;
  logic [2:0]  rm;
  logic [15:0] imm;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_write;
  logic [8:0]  count;
  logic        err;
  logic        full;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    logic [8:0]  cnt;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] exp_addr;
  logic [8:0] exp_count;
  int         tests  = 0;
  int         failed = 0;

  instr_encoder #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .alu_op    (alu_op),
    .shift_op  (shift_op),
    .rn        (rn),
    .rd        (rd),
    .rm        (rm),
    .imm       (imm),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .count     (count),
    .err       (err),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {24'h0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", {24'h0, mem_addr}, {24'h0, e.addr});
        check("write_data", {16'h0, mem_wdata}, {16'h0, e.data});
        check("write_count", {23'h0, count}, {23'h0, e.cnt});
      end
    end
  end

  // Move to 1 time unit after the next rising edge.
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Drive one bundle. Call at posedge+1 while in ACCEPT. With push=1 the
  // bundle is legal, its write is queued and the task returns after the write
  // cycle. With push=0 it returns right after the accepting edge.
  task automatic send(input logic [1:0] f, input logic [2:0] op, input logic [1:0] ao,
                      input logic [2:0] n, input logic [2:0] d, input logic [1:0] so,
                      input logic [2:0] m, input logic [15:0] i,
                      input bit push, input logic [15:0] w);
    wr_t e;
    fmt = f; opcode = op; alu_op = ao; rn = n; rd = d; shift_op = so; rm = m; imm = i;
    in_valid = 1'b1;
    @(negedge clk);
    check("in_ready_accept", {31'h0, in_ready}, 32'h1);
    if (push) begin
      exp_count = exp_count + 9'd1;
      e = '{exp_addr, w, exp_count};
      exp_q.push_back(e);
    end
    sync();
    in_valid = 1'b0;
    if (push) begin
      sync();
      exp_addr = exp_addr + 8'd1;
    end
  endtask

  task automatic pulse_start(input logic [7:0] b);
    start     = 1'b1;
    base_addr = b;
    sync();
    start     = 1'b0;
    exp_addr  = b;
    exp_count = 9'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_write"}, {31'h0, mem_write}, 32'h0);
    check({tag, "_in_ready"}, {31'h0, in_ready}, 32'h0);
    check({tag, "_mem_addr"}, {24'h0, mem_addr}, 32'h0);
    check({tag, "_mem_wdata"}, {16'h0, mem_wdata}, 32'h0);
    check({tag, "_count"}, {23'h0, count}, 32'h0);
    check({tag, "_err"}, {31'h0, err}, 32'h0);
    check({tag, "_full"}, {31'h0, full}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = 8'h00; in_valid = 1'b0;
    fmt = 2'b00; opcode = 3'd0; alu_op = 2'd0; shift_op = 2'd0;
    rn = 3'd0; rd = 3'd0; rm = 3'd0; imm = 16'h0000;
    exp_addr = 8'h00; exp_count = 9'd0;

    #12;
    check_all_zero("reset");
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", {31'h0, in_ready}, 32'h0);

    // start with a legal bundle offered in the same cycle: it must not be taken
    sync();
    start = 1'b1; base_addr = 8'h10;
    fmt = 2'b00; opcode = 3'b111; rn = 3'd7; in_valid = 1'b1;
    @(negedge clk);
    check("ready_during_start", {31'h0, in_ready}, 32'h0);
    sync();
    start = 1'b0; in_valid = 1'b0;
    exp_addr = 8'h10; exp_count = 9'd0;
    @(negedge clk);
    check("start_mem_addr", {24'h0, mem_addr}, 32'h10);
    check("start_count", {23'h0, count}, 32'h0);
    sync();

    // register, imm8 (negative) and imm5 (negative) formats; unused fields hold junk
    send(2'b00, 3'b101, 2'b00, 3'd1, 3'd2, 2'b01, 3'd3, 16'h1234, 1'b1, 16'hA14B);
    send(2'b01, 3'b110, 2'b10, 3'd3, 3'd7, 2'b11, 3'd7, 16'hFFFB, 1'b1, 16'hD3FB);
    send(2'b10, 3'b011, 2'b00, 3'd2, 3'd1, 2'b11, 3'd7, 16'hFFF0, 1'b1, 16'h6230);

    // illegal bundles: imm8 = +128, fmt 11, imm5 = +16
    send(2'b01, 3'b000, 2'b00, 3'd0, 3'd0, 2'b00, 3'd0, 16'h0080, 1'b0, 16'h0000);
    @(negedge clk);
    check("imm8_over_err", {31'h0, err}, 32'h1);
    check("imm8_over_count", {23'h0, count}, 32'h3);
    check("imm8_over_ready", {31'h0, in_ready}, 32'h1);
    sync();
    send(2'b11, 3'b000, 2'b00, 3'd0, 3'd0, 2'b00, 3'd0, 16'h0000, 1'b0, 16'h0000);
    send(2'b10, 3'b000, 2'b00, 3'd0, 3'd0, 2'b00, 3'd0, 16'h0010, 1'b0, 16'h0000);
    @(negedge clk);
    check("illegal_count", {23'h0, count}, 32'h3);
    check("illegal_err", {31'h0, err}, 32'h1);
    sync();
    // error does not stall acceptance: imm8 = -128 is legal
    send(2'b01, 3'b111, 2'b01, 3'd7, 3'd0, 2'b00, 3'd0, 16'hFF80, 1'b1, 16'hEF80);
    @(negedge clk);
    check("err_sticky", {31'h0, err}, 32'h1);
    sync();

    // load at the top of the address space; boundary immediates +127 and +15
    pulse_start(8'hFE);
    @(negedge clk);
    check("restart_err", {31'h0, err}, 32'h0);
    check("restart_count", {23'h0, count}, 32'h0);
    check("restart_full", {31'h0, full}, 32'h0);
    sync();
    send(2'b01, 3'b000, 2'b11, 3'd0, 3'd5, 2'b10, 3'd6, 16'h007F, 1'b1, 16'h187F);
    send(2'b10, 3'b001, 2'b00, 3'd4, 3'd7, 2'b11, 3'd5, 16'h000F, 1'b1, 16'h24EF);
    @(negedge clk);
    check("full_flag", {31'h0, full}, 32'h1);
    check("full_in_ready", {31'h0, in_ready}, 32'h0);
    check("full_count", {23'h0, count}, 32'h2);
    check("full_mem_addr", {24'h0, mem_addr}, 32'hFF);
    fmt = 2'b00; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("full_ignore_count", {23'h0, count}, 32'h2);
    check("full_ignore_ready", {31'h0, in_ready}, 32'h0);
    sync();

    // asynchronous reset in the middle of a write cycle
    pulse_start(8'h20);
    send(2'b00, 3'b001, 2'b01, 3'd1, 3'd1, 2'b01, 3'd1, 16'h0000, 1'b0, 16'h0000);
    #1;
    check("pre_reset_mem_write", {31'h0, mem_write}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    sync();
    rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_ready", {31'h0, in_ready}, 32'h0);
    check("post_reset_count", {23'h0, count}, 32'h0);
    in_valid = 1'b0;
    sync();

    // start during a write cycle drops that write
    pulse_start(8'h40);
    send(2'b00, 3'b001, 2'b01, 3'd1, 3'd1, 2'b01, 3'd1, 16'h0000, 1'b0, 16'h0000);
    start = 1'b1; base_addr = 8'h50;
    @(negedge clk);
    check("start_in_write_drop", {31'h0, mem_write}, 32'h0);
    sync();
    start = 1'b0;
    exp_addr = 8'h50; exp_count = 9'd0;
    @(negedge clk);
    check("start_in_write_addr", {24'h0, mem_addr}, 32'h50);
    check("start_in_write_count", {23'h0, count}, 32'h0);
    sync();
    send(2'b00, 3'b010, 2'b01, 3'd5, 3'd6, 2'b10, 3'd4, 16'hFFFF, 1'b1, 16'h4DD4);

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory address width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port start  input  1  single-cycle pulse that opens a new program load.
REQ-005 SHALL have port base_addr  input  ADDR_W  first write address, sampled on start.
REQ-006 SHALL have port in_valid / in_ready  input / output  1 each  field-bundle handshake.
REQ-007 SHALL have port fmt  input  2  field format: 00 register, 01 imm8, 10 imm5, 11 illegal.
REQ-008 SHALL have ports opcode (3), alu_op (2), shift_op (2), rn (3), rd (3), rm (3)  input  instruction fields.
REQ-009 SHALL have port imm  input  16  two's-complement immediate.
REQ-010 SHALL have ports mem_addr (ADDR_W), mem_wdata (16), mem_write (1)  output  memory write port.
REQ-011 SHALL have ports count (ADDR_W+1), err (1), full (1)  output  words written, sticky error, load full.

Function
REQ-012 SHALL implement FSM states IDLE, ACCEPT, WRITE, FULL.
REQ-013 IDLE: in_ready=0; start -> ACCEPT.
REQ-014 ACCEPT: in_ready=1; in_valid with a legal bundle -> capture word, go WRITE; in_valid with an illegal bundle -> set err, discard, stay ACCEPT.
REQ-015 WRITE: mem_write=1 for exactly one cycle at mem_addr; count increments; if mem_addr is all-ones -> FULL, else mem_addr increments and state returns to ACCEPT.
REQ-016 FULL: in_ready=0, full=1, mem_addr holds the last written address; no address wrap.
REQ-017 Latency: a bundle accepted in cycle N SHALL be written in cycle N+1; peak throughput is one word per 2 cycles.
REQ-018 Word packing SHALL be: [15:13]=opcode, [12:11]=alu_op, [10:8]=rn.
REQ-019 fmt 00 SHALL pack [7:5]=rd, [4:3]=shift_op, [2:0]=rm; imm is ignored.
REQ-020 fmt 01 SHALL pack [7:0]=imm[7:0]; rd, shift_op, and rm are ignored.
REQ-021 fmt 10 SHALL pack [7:5]=rd, [4:0]=imm[4:0]; shift_op and rm are ignored.
REQ-022 The bundle SHALL be illegal when fmt=11, when fmt=01 and imm is outside -128..127, or when fmt=10 and imm is outside -16..15 (upper bits not a sign extension).
REQ-023 mem_wdata SHALL hold the captured word from capture until the next capture.
REQ-024 start SHALL take priority in every state: any pending write is dropped (no mem_write), mem_addr<=base_addr, count<=0, err<=0, full<=0, next state ACCEPT.
REQ-025 A bundle presented in the same cycle as start SHALL NOT be accepted (in_ready=0 that cycle).
REQ-026 err SHALL be sticky until start or reset; the error SHALL NOT stall acceptance.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, in_ready=0, mem_write=0, mem_addr=0, mem_wdata=0, count=0, err=0, and full=0, independent of clk.
REQ-028 Reset during WRITE SHALL suppress that write; no further write SHALL occur until after the next start.

Verification
REQ-029 Bench: start with base_addr=0x10; then fmt=00, opcode=101, alu_op=00, rn=1, rd=2, shift_op=01, rm=3 -> next cycle mem_write=1, mem_addr=0x10, mem_wdata=0xA14B, count=1.
REQ-030 Bench: fmt=01, opcode=110, alu_op=10, rn=3, imm=0xFFFB -> mem_wdata=0xD3FB; fmt=10, opcode=011, alu_op=00, rn=2, rd=1, imm=0xFFF0 -> mem_wdata=0x6230 at the next address.
REQ-031 Bench: fmt=01 with imm=0x0080, then fmt=11 -> err=1, no mem_write, count unchanged, in_ready stays 1; the next start clears err.
REQ-032 Bench: base_addr=0xFE, two legal bundles -> writes at 0xFE and 0xFF, then full=1, in_ready=0, count=2; extra in_valid is ignored.
REQ-033 Bench: assert rst_n=0 mid-cycle during WRITE -> mem_write drops before the next clk edge and all outputs are zero; start during WRITE -> the write is dropped and mem_addr=base_addr.
